// File: rtl/peatc_sweep_sequencer.sv
// PEATC sweep sequencer: pops one host test command, then runs NSW
// stimulus/acquisition sweeps, streaming NSMP raw samples per sweep from
// the raw-sample RAM into the host TX FIFO with a programmable gap.
`timescale 1ns/1ps
module peatc_sweep_sequencer #(
   parameter int unsigned ACQ_TIMEOUT = 4096,
   parameter int unsigned GAP_SCALE   = 16
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic        iCmdEmpty,
   input  logic [31:0] i32CmdData,
   output logic        oCmdRdEn,
   output logic        oAcqStart,
   output logic [7:0]  o8SignSelec,
   input  logic        iAcqReady,
   output logic [7:0]  o8RamAddr,
   output logic        oRamRdEn,
   input  logic [15:0] i16RamData,
   output logic        oTxWrEn,
   output logic [15:0] o16TxData,
   input  logic        iTxFull,
   output logic        oBusy,
   output logic [7:0]  o8SweepIdx,
   output logic        oSweepDone,
   output logic        oCmdError
);

   localparam int unsigned TMO_W = $clog2(ACQ_TIMEOUT + 1);
   localparam int unsigned GAP_W = 16;

   typedef enum logic [2:0] {
      S_IDLE, S_LATCH, S_START, S_WAIT_ACQ,
      S_RAM_RD, S_RAM_CAP, S_TX_WR, S_GAP
   } state_t;

   state_t           state;
   logic [7:0]       nsw;
   logic [7:0]       nsmp;
   logic [7:0]       gap_units;
   logic [7:0]       addr;
   logic [7:0]       sweep;
   logic [15:0]      hold;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;

   // addr, sweep index and sample hold register are the outputs themselves
   assign o8RamAddr  = addr;
   assign o8SweepIdx = sweep;
   assign o16TxData  = hold;

   // sequencer FSM; every strobe is a registered single-cycle pulse
   always_ff @(posedge iClk) begin
      if (!iReset) begin
         state       <= S_IDLE;
         nsw         <= '0;
         nsmp        <= '0;
         gap_units   <= '0;
         addr        <= '0;
         sweep       <= '0;
         hold        <= '0;
         tmo_cnt     <= '0;
         gap_cnt     <= '0;
         o8SignSelec <= '0;
         oCmdRdEn    <= 1'b0;
         oAcqStart   <= 1'b0;
         oRamRdEn    <= 1'b0;
         oTxWrEn     <= 1'b0;
         oBusy       <= 1'b0;
         oSweepDone  <= 1'b0;
         oCmdError   <= 1'b0;
      end else begin
         oCmdRdEn   <= 1'b0;
         oAcqStart  <= 1'b0;
         oRamRdEn   <= 1'b0;
         oTxWrEn    <= 1'b0;
         oSweepDone <= 1'b0;
         oCmdError  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!iCmdEmpty) begin
                  oCmdRdEn <= 1'b1;
                  oBusy    <= 1'b1;
                  state    <= S_LATCH;
               end
            end
            S_LATCH: begin
               // first LATCH cycle is the pop itself; FIFO dout is valid on the second
               if (!oCmdRdEn) begin
                  if ((i32CmdData[31:24] == 8'd0) || (i32CmdData[15:8] == 8'd0)) begin
                     oCmdError <= 1'b1;
                     oBusy     <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     nsw         <= i32CmdData[31:24];
                     o8SignSelec <= i32CmdData[23:16];
                     nsmp        <= i32CmdData[15:8];
                     gap_units   <= i32CmdData[7:0];
                     sweep       <= '0;
                     state       <= S_START;
                  end
               end
            end
            S_START: begin
               oAcqStart <= 1'b1;
               tmo_cnt   <= '0;
               state     <= S_WAIT_ACQ;
            end
            S_WAIT_ACQ: begin
               if (iAcqReady) begin
                  addr     <= '0;
                  oRamRdEn <= 1'b1;
                  state    <= S_RAM_RD;
               end else if (tmo_cnt == TMO_W'(ACQ_TIMEOUT - 1)) begin
                  oCmdError <= 1'b1;
                  oBusy     <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            S_RAM_RD: begin
               state <= S_RAM_CAP;
            end
            S_RAM_CAP: begin
               hold  <= i16RamData;
               state <= S_TX_WR;
            end
            S_TX_WR: begin
               // hold here while the TX FIFO is full; hold register stays put
               if (!iTxFull) begin
                  oTxWrEn <= 1'b1;
                  if (addr == nsmp - 8'd1) begin
                     if (sweep == nsw - 8'd1) begin
                        oSweepDone <= 1'b1;
                        oBusy      <= 1'b0;
                        state      <= S_IDLE;
                     end else begin
                        gap_cnt <= GAP_W'(gap_units) * GAP_W'(GAP_SCALE);
                        state   <= S_GAP;
                     end
                  end else begin
                     addr     <= addr + 8'd1;
                     oRamRdEn <= 1'b1;
                     state    <= S_RAM_RD;
                  end
               end
            end
            S_GAP: begin
               // stays max(1, GAP*GAP_SCALE) cycles
               if (gap_cnt <= GAP_W'(1)) begin
                  sweep <= sweep + 8'd1;
                  state <= S_START;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               oBusy <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_peatc_sweep_sequencer.sv
// Directed bench for peatc_sweep_sequencer with RX FIFO, acquisition,
// raw-sample RAM and TX FIFO models.
`timescale 1ns/1ps
module tb_peatc_sweep_sequencer;

   localparam int unsigned ACQ_TIMEOUT = 4096;
   localparam int unsigned GAP_SCALE   = 16;

   logic        iClk;
   logic        iReset;
   logic        iCmdEmpty;
   logic [31:0] i32CmdData;
   logic        oCmdRdEn;
   logic        oAcqStart;
   logic [7:0]  o8SignSelec;
   logic        iAcqReady;
   logic [7:0]  o8RamAddr;
   logic        oRamRdEn;
   logic [15:0] i16RamData;
   logic        oTxWrEn;
   logic [15:0] o16TxData;
   logic        iTxFull;
   logic        oBusy;
   logic [7:0]  o8SweepIdx;
   logic        oSweepDone;
   logic        oCmdError;

   peatc_sweep_sequencer #(.ACQ_TIMEOUT(ACQ_TIMEOUT), .GAP_SCALE(GAP_SCALE)) dut (
      .iClk(iClk), .iReset(iReset), .iCmdEmpty(iCmdEmpty), .i32CmdData(i32CmdData),
      .oCmdRdEn(oCmdRdEn), .oAcqStart(oAcqStart), .o8SignSelec(o8SignSelec),
      .iAcqReady(iAcqReady), .o8RamAddr(o8RamAddr), .oRamRdEn(oRamRdEn),
      .i16RamData(i16RamData), .oTxWrEn(oTxWrEn), .o16TxData(o16TxData),
      .iTxFull(iTxFull), .oBusy(oBusy), .o8SweepIdx(o8SweepIdx),
      .oSweepDone(oSweepDone), .oCmdError(oCmdError)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // RX FIFO model: dout updates the cycle after the read enable
   logic [31:0] rx_mem [16];
   int rx_wr = 0;
   int rx_rd = 0;
   assign iCmdEmpty = (rx_rd == rx_wr);
   always @(posedge iClk) begin
      if (oCmdRdEn) begin
         i32CmdData <= rx_mem[rx_rd % 16];
         rx_rd      <= rx_rd + 1;
      end
   end

   task automatic push_cmd(input logic [31:0] c);
      rx_mem[rx_wr % 16] = c;
      rx_wr++;
   endtask

   // acquisition model: one-cycle ready 3 cycles after each start
   logic ready_en;
   int   acq_cd = 0;
   always @(posedge iClk) begin
      if (oAcqStart && ready_en) acq_cd <= 3;
      else if (acq_cd != 0)      acq_cd <= acq_cd - 1;
   end
   assign iAcqReady = ready_en && (acq_cd == 1);

   // raw-sample RAM model: RAM[a] = 0x1000 + a, one-cycle read latency
   always @(posedge iClk) begin
      if (oRamRdEn) i16RamData <= 16'h1000 + 16'(o8RamAddr);
   end

   // event monitor / TX FIFO sink
   int          cyc = 0;
   int          n_start = 0, n_done = 0, n_rd = 0, n_err = 0, n_wr = 0, n_full_viol = 0;
   int          t_rd = 0, t_err = 0, done_wr = 0;
   logic        err_d = 1'b0;
   logic        busy_after_err = 1'b1;
   logic [15:0] tx_log   [256];
   int          tx_t     [256];
   int          start_t  [64];
   logic [7:0]  start_idx[64];
   logic [7:0]  start_sel[64];
   always @(posedge iClk) begin
      cyc   <= cyc + 1;
      err_d <= oCmdError;
      if (err_d) busy_after_err <= oBusy;
      if (oCmdRdEn) begin n_rd <= n_rd + 1; t_rd <= cyc; end
      if (oCmdError) begin n_err <= n_err + 1; t_err <= cyc; end
      if (oAcqStart) begin
         start_t[n_start % 64]   <= cyc;
         start_idx[n_start % 64] <= o8SweepIdx;
         start_sel[n_start % 64] <= o8SignSelec;
         n_start <= n_start + 1;
      end
      if (oTxWrEn) begin
         tx_log[n_wr % 256] <= o16TxData;
         tx_t[n_wr % 256]   <= cyc;
         n_wr <= n_wr + 1;
         if (iTxFull) n_full_viol <= n_full_viol + 1;
      end
      if (oSweepDone) begin
         n_done  <= n_done + 1;
         done_wr <= oTxWrEn ? n_wr + 1 : -1;
      end
   end

   task automatic wait_busy(input logic lvl, input int budget, input string tag);
      int k = 0;
      while (oBusy !== lvl && k < budget) begin
         @(negedge iClk);
         k++;
      end
      chk(tag, 32'(oBusy), 32'(lvl));
   endtask

   int b_wr, b_start, b_done, b_rd, b_err, viol, k;

   task automatic snap();
      b_wr = n_wr; b_start = n_start; b_done = n_done; b_rd = n_rd; b_err = n_err;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      iReset   = 1'b0;
      iTxFull  = 1'b0;
      ready_en = 1'b1;
      repeat (3) @(negedge iClk);
      chk("rst_ctrl", {17'd0, oCmdRdEn, oAcqStart, oRamRdEn, oTxWrEn, oBusy, oSweepDone, oCmdError, o8SignSelec}, 32'd0);
      chk("rst_data", {o8RamAddr, o8SweepIdx, o16TxData}, 32'd0);
      iReset = 1'b1;
      @(negedge iClk);

      // two sweeps of four samples, no gap
      snap();
      push_cmd(32'h0205_0400);
      wait_busy(1'b1, 10, "t1_busy_up");
      wait_busy(1'b0, 300, "t1_busy_down");
      @(negedge iClk);
      chk("t1_wr_count", 32'(n_wr - b_wr), 32'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("t1_tx%0d", i), 32'(tx_log[(b_wr + i) % 256]), 32'h1000 + 32'(i % 4));
      chk("t1_starts", 32'(n_start - b_start), 32'd2);
      chk("t1_done_cnt", 32'(n_done - b_done), 32'd1);
      chk("t1_done_on_8th", 32'(done_wr - b_wr), 32'd8);
      chk("t1_pops", 32'(n_rd - b_rd), 32'd1);
      chk("t1_rate", 32'(tx_t[(b_wr + 1) % 256] - tx_t[b_wr % 256]), 32'd3);
      chk("t1_sel", 32'(start_sel[b_start % 64]), 32'h05);
      chk("t1_idx0", 32'(start_idx[b_start % 64]), 32'd0);
      chk("t1_idx1", 32'(start_idx[(b_start + 1) % 64]), 32'd1);

      // NSW==0 is rejected
      snap();
      push_cmd(32'h0001_1000);
      wait_busy(1'b1, 10, "t2_busy_up");
      wait_busy(1'b0, 20, "t2_busy_down");
      repeat (2) @(negedge iClk);
      chk("t2_err", 32'(n_err - b_err), 32'd1);
      chk("t2_no_start", 32'(n_start - b_start), 32'd0);
      chk("t2_no_wr", 32'(n_wr - b_wr), 32'd0);
      chk("t2_err_lat", 32'(t_err - t_rd), 32'd2);

      // acquisition never completes
      snap();
      ready_en = 1'b0;
      push_cmd(32'h0101_0300);
      wait_busy(1'b1, 10, "t3_busy_up");
      wait_busy(1'b0, ACQ_TIMEOUT + 100, "t3_busy_down");
      repeat (2) @(negedge iClk);
      chk("t3_err", 32'(n_err - b_err), 32'd1);
      chk("t3_tmo", 32'(t_err - start_t[b_start % 64]), 32'(ACQ_TIMEOUT));
      chk("t3_busy_after", 32'(busy_after_err), 32'd0);
      chk("t3_no_wr", 32'(n_wr - b_wr), 32'd0);
      ready_en = 1'b1;

      // TX full held for 20 cycles at sample 1
      snap();
      push_cmd(32'h0102_0400);
      wait_busy(1'b1, 10, "t4_busy_up");
      k = 0;
      while (!(oRamRdEn && o8RamAddr == 8'd1) && k < 100) begin
         @(negedge iClk);
         k++;
      end
      chk("t4_sync", 32'(oRamRdEn), 32'd1);
      @(negedge iClk);
      iTxFull = 1'b1;
      viol = 0;
      repeat (20) begin
         @(negedge iClk);
         if (oTxWrEn) viol++;
      end
      chk("t4_hold_data", 32'(o16TxData), 32'h1001);
      iTxFull = 1'b0;
      chk("t4_wr_in_full", 32'(viol), 32'd0);
      wait_busy(1'b0, 200, "t4_busy_down");
      @(negedge iClk);
      chk("t4_wr_count", 32'(n_wr - b_wr), 32'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t4_tx%0d", i), 32'(tx_log[(b_wr + i) % 256]), 32'h1000 + 32'(i));
      chk("t4_full_viol", 32'(n_full_viol), 32'd0);

      // gap of 3 units = 48 cycles between the write and the next start
      snap();
      push_cmd(32'h0201_0103);
      wait_busy(1'b1, 10, "t5_busy_up");
      wait_busy(1'b0, 400, "t5_busy_down");
      @(negedge iClk);
      chk("t5_wr_count", 32'(n_wr - b_wr), 32'd2);
      chk("t5_gap", 32'(start_t[(b_start + 1) % 64] - tx_t[b_wr % 256] - 1), 32'd48);

      // reset during RAM_RD of sweep 1; the queued command runs cleanly
      push_cmd(32'h0203_0200);
      push_cmd(32'h0104_0200);
      wait_busy(1'b1, 10, "t6_busy_up");
      k = 0;
      while (!(oRamRdEn && o8SweepIdx == 8'd1) && k < 200) begin
         @(negedge iClk);
         k++;
      end
      chk("t6_sync", 32'(oRamRdEn), 32'd1);
      iReset = 1'b0;
      @(negedge iClk);
      chk("t6_rst_ctrl", {17'd0, oCmdRdEn, oAcqStart, oRamRdEn, oTxWrEn, oBusy, oSweepDone, oCmdError, o8SignSelec}, 32'd0);
      chk("t6_rst_data", {o8RamAddr, o8SweepIdx, o16TxData}, 32'd0);
      iReset = 1'b1;
      snap();
      wait_busy(1'b1, 10, "t6_busy_up2");
      wait_busy(1'b0, 200, "t6_busy_down");
      @(negedge iClk);
      chk("t6_starts", 32'(n_start - b_start), 32'd1);
      chk("t6_idx", 32'(start_idx[b_start % 64]), 32'd0);
      chk("t6_sel", 32'(start_sel[b_start % 64]), 32'h04);
      chk("t6_wr_count", 32'(n_wr - b_wr), 32'd2);
      chk("t6_tx0", 32'(tx_log[b_wr % 256]), 32'h1000);
      chk("t6_tx1", 32'(tx_log[(b_wr + 1) % 256]), 32'h1001);
      chk("t6_done", 32'(n_done - b_done), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
